// File: rtl/fpu_pkg.sv
// Shared FPU definitions: conversion op encoding and the
// bookkeeping record that follows an operation through a converter.
package fpu_pkg;

    localparam logic OP_ITOF = 1'b0;
    localparam logic OP_FTOI = 1'b1;

    // Widest requester index and tag the tracking record can carry.
    localparam int ID_W  = 8;
    localparam int TAG_W = 16;

    typedef struct packed {
        logic             vld;
        logic [ID_W-1:0]  id;
        logic             op;
        logic [TAG_W-1:0] tag;
    } pipe_t;

endpackage

// File: rtl/fcvt_resp_fifo.sv
// Per-requester response FIFO: circular buffer of DEPTH words,
// head word presented from registered storage.
module fcvt_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [CW-1:0] cnt;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            if (push) begin
                mem[wr] <= push_data;
                wr      <= nxt(wr);
            end
            if (pop) rd <= nxt(rd);
            if (push && !pop) cnt <= cnt + 1'b1;
            else if (!push && pop) cnt <= cnt - 1'b1;
        end
    end

    assign head  = mem[rd];
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/fcvt_sched.sv
// Shared int<->float converter scheduler: round-robin credit-based
// issue, latency-matched tracking pipe, per-requester response FIFOs.
module fcvt_sched
    import fpu_pkg::*;
#(
    parameter int N     = 2,
    parameter int LAT   = 1,
    parameter int TAGW  = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req_valid,
    output logic [N-1:0]             req_ready,
    input  logic [N-1:0]             req_op,
    input  logic [N-1:0][31:0]       req_a,
    input  logic [N-1:0][TAGW-1:0]   req_tag,
    output logic [31:0]              itof_a,
    input  logic [31:0]              itof_c,
    output logic [31:0]              ftoi_a,
    input  logic [31:0]              ftoi_c,
    output logic [N-1:0]             resp_valid,
    input  logic [N-1:0]             resp_ready,
    output logic [N-1:0][31:0]       resp_data,
    output logic [N-1:0][TAGW-1:0]   resp_tag
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = 32 + TAGW;

    logic [IW-1:0] ptr;
    logic [IW-1:0] gid;
    logic          gnt;
    logic [N-1:0]  elig;
    logic [N-1:0]  push;
    logic [N-1:0]  pop;
    logic [N-1:0]  full;
    logic [N-1:0]  empty;
    logic [CW-1:0] credit [N];
    logic [FW-1:0] head [N];
    pipe_t         pipe [LAT];
    pipe_t         last;
    logic [31:0]   res;

    // A requester may issue only while it still owns a free FIFO slot.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++)
            elig[i] = req_valid[i] && !full[i] &&
                      (credit[i] < CW'(DEPTH));
    end

    // Round-robin search starting at ptr; nothing is granted in reset.
    always_comb begin
        gnt = 1'b0;
        gid = '0;
        for (int k = 0; k < N; k++) begin
            if (!gnt && elig[(int'(ptr) + k) % N]) begin
                gnt = 1'b1;
                gid = IW'((int'(ptr) + k) % N);
            end
        end
        if (rst) gnt = 1'b0;
    end

    // Grant strobe and operand steering; idle operands are zero.
    always_comb begin
        req_ready = '0;
        itof_a    = '0;
        ftoi_a    = '0;
        if (gnt) begin
            req_ready[gid] = 1'b1;
            if (req_op[gid] == OP_FTOI) ftoi_a = req_a[gid];
            else                        itof_a = req_a[gid];
        end
    end

    // Round-robin pointer moves just past the last winner.
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (gnt)
            ptr <= (gid == IW'(N - 1)) ? '0 : gid + 1'b1;
    end

    // Tracking pipe mirrors the converter latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= '{vld: gnt,
                         id:  ID_W'(gid),
                         op:  req_op[gid],
                         tag: TAG_W'(req_tag[gid])};
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign last = pipe[LAT-1];
    assign res  = (last.op == OP_FTOI) ? ftoi_c : itof_c;

    // Route the completing result to its owner's FIFO.
    always_comb begin
        push = '0;
        for (int i = 0; i < N; i++)
            push[i] = last.vld && (last.id == ID_W'(i));
    end

    assign resp_valid = ~empty;
    assign pop        = resp_valid & resp_ready;

    // Credits count in-flight ops plus queued responses.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) credit[i] <= '0;
            else if (req_ready[i] && !pop[i]) credit[i] <= credit[i] + 1'b1;
            else if (!req_ready[i] && pop[i]) credit[i] <= credit[i] - 1'b1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_fifo
        fcvt_resp_fifo #(
            .DEPTH (DEPTH),
            .W     (FW)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_data ({res, last.tag[TAGW-1:0]}),
            .pop       (pop[i]),
            .head      (head[i]),
            .empty     (empty[i]),
            .full      (full[i])
        );
        assign resp_data[i] = head[i][FW-1:TAGW];
        assign resp_tag[i]  = head[i][TAGW-1:0];
    end

endmodule

// File: tb/tb_fcvt_sched.sv
// Bench for fcvt_sched: converter models, queue-based reference
// model checked every cycle, directed table and corner sequences.
module tb_fcvt_sched;

    localparam int N     = 2;
    localparam int LAT   = 1;
    localparam int TAGW  = 4;
    localparam int DEPTH = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0]           req_valid = '0;
    logic [N-1:0]           req_ready;
    logic [N-1:0]           req_op = '0;
    logic [N-1:0][31:0]     req_a = '0;
    logic [N-1:0][TAGW-1:0] req_tag = '0;
    logic [31:0]            itof_a, itof_c, ftoi_a, ftoi_c;
    logic [N-1:0]           resp_valid;
    logic [N-1:0]           resp_ready = '1;
    logic [N-1:0][31:0]     resp_data;
    logic [N-1:0][TAGW-1:0] resp_tag;

    always #5 clk = ~clk;

    fcvt_sched #(.N(N), .LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_tag(req_tag),
        .itof_a(itof_a), .itof_c(itof_c),
        .ftoi_a(ftoi_a), .ftoi_c(ftoi_c),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag)
    );

    // Reference conversions: round-to-nearest-even, truncate+saturate.
    function automatic logic [31:0] itof_fn(input logic [31:0] x);
        logic [31:0] mag;
        logic [63:0] m, rem, half;
        int p, e;
        logic s;
        if (x == 32'd0) return 32'd0;
        s = x[31];
        mag = s ? (~x + 32'd1) : x;
        p = 0;
        for (int b = 0; b < 32; b++) if (mag[b]) p = b;
        e = 127 + p;
        if (p <= 23) m = 64'(mag) << (23 - p);
        else begin
            m = 64'(mag) >> (p - 23);
            rem = 64'(mag) & ((64'd1 << (p - 23)) - 64'd1);
            half = 64'd1 << (p - 24);
            if (rem > half || (rem == half && m[0])) m = m + 64'd1;
            if (m[24]) begin m = m >> 1; e++; end
        end
        return {s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] ftoi_fn(input logic [31:0] f);
        int e;
        logic [63:0] mag;
        e = int'(f[30:23]);
        if (e < 127) return 32'd0;
        if (e == 255 && f[22:0] != 23'd0) return 32'h7FFFFFFF;
        if (e >= 158) return f[31] ? 32'h80000000 : 32'h7FFFFFFF;
        mag = {40'd0, 1'b1, f[22:0]};
        if (e - 127 >= 23) mag = mag << (e - 127 - 23);
        else mag = mag >> (23 - (e - 127));
        return f[31] ? (~mag[31:0] + 32'd1) : mag[31:0];
    endfunction

    // Converter units with LAT-cycle latency.
    logic [31:0] itof_p [LAT];
    logic [31:0] ftoi_p [LAT];
    initial for (int k = 0; k < LAT; k++) begin
        itof_p[k] = '0;
        ftoi_p[k] = '0;
    end
    always @(posedge clk) begin
        itof_p[0] <= itof_a;
        ftoi_p[0] <= ftoi_a;
        for (int k = 1; k < LAT; k++) begin
            itof_p[k] <= itof_p[k-1];
            ftoi_p[k] <= ftoi_p[k-1];
        end
    end
    assign itof_c = itof_fn(itof_p[LAT-1]);
    assign ftoi_c = ftoi_fn(ftoi_p[LAT-1]);

    // Reference model: one queue per requester holds every op it owns
    // (in flight or waiting); its length is the credit.
    typedef struct {
        logic [31:0]     d;
        logic [TAGW-1:0] t;
        int              rdy;
    } ent_t;
    ent_t q [N][$];
    int mptr = 0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [N-1:0] last_rdy, last_rvld;
    logic [N-1:0][31:0] last_data;
    logic [N-1:0][TAGW-1:0] last_tag;
    int last_g;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0] ev, er, pops;
        logic [31:0] ei, ef, cd;
        logic cop;
        logic [31:0] ca;
        logic [TAGW-1:0] ct;
        int g, j;
        #1;
        ev = '0;
        for (int i = 0; i < N; i++)
            if (q[i].size() > 0 && q[i][0].rdy <= cyc) ev[i] = 1'b1;
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        for (int i = 0; i < N; i++) if (ev[i]) begin
            chk("resp_data", resp_data[i], q[i][0].d);
            chk("resp_tag", 32'(resp_tag[i]), 32'(q[i][0].t));
        end
        g = -1;
        if (!rst) for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (g < 0 && req_valid[j] && q[j].size() < DEPTH) g = j;
        end
        er = '0; ei = '0; ef = '0;
        cop = 1'b0; ca = '0; ct = '0;
        if (g >= 0) begin
            er[g] = 1'b1;
            cop = req_op[g]; ca = req_a[g]; ct = req_tag[g];
            if (cop) ef = ca; else ei = ca;
        end
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("itof_a", itof_a, ei);
        chk("ftoi_a", ftoi_a, ef);
        chk("push_full", 32'(dut.push & dut.full), 32'd0);
        pops = ev & resp_ready;
        last_rdy = req_ready;
        last_rvld = resp_valid;
        last_data = resp_data;
        last_tag = resp_tag;
        last_g = g;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) q[i].delete();
            mptr = 0;
        end else begin
            for (int i = 0; i < N; i++) if (pops[i]) q[i].delete(0);
            if (g >= 0) begin
                cd = cop ? ftoi_fn(ca) : itof_fn(ca);
                q[g].push_back('{d: cd, t: ct, rdy: cyc + LAT + 1});
                mptr = (g + 1) % N;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        resp_ready = '1;
        for (int k = 0; k < n; k++) step();
    endtask

    typedef struct {
        int              who;
        logic            op;
        logic [31:0]     a;
        logic [TAGW-1:0] tag;
        logic [31:0]     exp;
    } vec_t;
    vec_t tbl [9];

    function automatic logic [31:0] pick_a();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 1000));
            2: return {1'($urandom_range(0, 1)),
                       8'($urandom_range(120, 160)),
                       23'($urandom)};
            default: return -32'($urandom_range(1, 5000));
        endcase
    endfunction

    initial begin
        int w, lat, g0, g1, both, alt, ng, prev, quiet;
        logic acc, got;
        logic [31:0] ld;
        logic [TAGW-1:0] lt;

        tbl[0] = '{0, 1'b0, 32'hFFFFFFFF, 4'd3, 32'hBF800000};
        tbl[1] = '{0, 1'b0, 32'h00000005, 4'd1, 32'h40A00000};
        tbl[2] = '{1, 1'b1, 32'h40A00000, 4'd2, 32'h00000005};
        tbl[3] = '{1, 1'b0, 32'h00000000, 4'd4, 32'h00000000};
        tbl[4] = '{0, 1'b1, 32'h3FC00000, 4'd5, 32'h00000001};
        tbl[5] = '{1, 1'b1, 32'hC0400000, 4'd6, 32'hFFFFFFFD};
        tbl[6] = '{0, 1'b0, 32'h80000000, 4'd7, 32'hCF000000};
        tbl[7] = '{1, 1'b1, 32'h7F800000, 4'd8, 32'h7FFFFFFF};
        tbl[8] = '{0, 1'b0, 32'h01000001, 4'd9, 32'h4B800000};

        // Reset with requests pending: nothing may be granted.
        rst = 1'b1;
        req_valid = '1;
        @(posedge clk);
        @(negedge clk);
        step();
        chk("rst_data", resp_data, 32'd0);
        chk("rst_tag", 32'(resp_tag), 32'd0);
        rst = 1'b0;
        drain(2);

        // Directed single operations: latency, data, tag.
        foreach (tbl[n]) begin
            w = tbl[n].who;
            req_op[w] = tbl[n].op;
            req_a[w] = tbl[n].a;
            req_tag[w] = tbl[n].tag;
            req_valid[w] = 1'b1;
            acc = 1'b0;
            for (int k = 0; k < 20 && !acc; k++) begin
                step();
                acc = last_rdy[w];
            end
            chk("tbl_accept", 32'(acc), 32'd1);
            req_valid[w] = 1'b0;
            got = 1'b0; lat = 0; ld = '0; lt = '0;
            for (int k = 1; k <= 20 && !got; k++) begin
                step();
                if (last_rvld[w]) begin
                    got = 1'b1; lat = k;
                    ld = last_data[w]; lt = last_tag[w];
                end
            end
            chk("tbl_latency", lat, LAT + 1);
            chk("tbl_data", ld, tbl[n].exp);
            chk("tbl_tag", 32'(lt), 32'(tbl[n].tag));
        end

        // Contention: both always valid, grants must alternate.
        drain(4);
        req_valid = '1;
        prev = -1; alt = 0; ng = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (last_g >= 0) begin
                ng++;
                if (last_g == prev) alt++;
                prev = last_g;
            end
            for (int i = 0; i < N; i++)
                if (last_rdy[i]) req_a[i] = pick_a();
        end
        chk("cont_grants", ng, 12);
        chk("cont_alternate", alt, 0);

        // Credit stall: req0 blocked after DEPTH grants.
        drain(5);
        req_valid = '1;
        resp_ready = 2'b10;
        g0 = 0; g1 = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (last_rdy[0]) g0++;
            if (k >= 4 && last_rdy[1]) g1++;
        end
        chk("stall_g0", g0, DEPTH);
        chk("stall_g1_runs", 32'(g1 > 0), 32'd1);
        resp_ready = 2'b11;
        step();
        g0 = last_rdy[0] ? 1 : 0;
        resp_ready = 2'b10;
        for (int k = 0; k < 6; k++) begin
            step();
            if (last_rdy[0]) g0++;
        end
        chk("stall_release", g0, 1);

        // Same-cycle grant and pop for one requester.
        req_valid = 2'b01;
        resp_ready = 2'b01;
        both = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (last_rdy[0] && last_rvld[0]) both++;
        end
        chk("grant_pop_seen", 32'(both > 0), 32'd1);

        // Reset right after a grant: that op must vanish.
        drain(6);
        req_op[0] = 1'b0; req_a[0] = 32'd7; req_tag[0] = 4'd5;
        req_valid = 2'b01;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            step();
            acc = last_rdy[0];
        end
        chk("rst_mid_accept", 32'(acc), 32'd1);
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        quiet = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (last_rvld != '0) quiet++;
        end
        chk("rst_mid_no_resp", quiet, 0);
        req_valid = '1;
        step();
        chk("rst_ptr_zero", last_g, 0);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) if (last_rdy[i]) req_valid[i] = 1'b0;
            step();
        end

        // Randomised traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_rdy[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_op[i] = 1'($urandom_range(0, 1));
                    req_a[i] = pick_a();
                    req_tag[i] = TAGW'($urandom);
                end
                resp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        drain(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
